hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard-detection and operand-forwarding unit for the pipelined MIPS CPU.
//  Sits between ID and the post-ID stages (EXE, MEM, WB, ...).
//  Keeps its own scoreboard of in-flight destination registers, one entry per post-ID stage.
//  Forwards the youngest matching result to NUM_SRC ID operands.
//  Raises id_stall when the producer's data does not exist yet (e.g. load-use).
// PARAMETERS
//  DATA_W        32  operand/result width
//  REG_AW         5  register address width; register 0 is never tracked or forwarded
//  NUM_SRC        2  number of ID source operands (rs, rt, ...)
//  DEPTH          3  number of post-ID stages tracked; entry 0 = EXE, DEPTH-1 = WB
//  LOAD_RDY_STG   1  first stage index at which load data is valid (1 = MEM)
//  FLUSH_DEPTH    1  number of youngest tracker entries invalidated by flush
// PORTS
//  clk            in   1               clock, rising edge
//  rst_n          in   1               asynchronous reset, active low
//  pipe_en        in   1               global pipeline advance; 0 = freeze tracker
//  flush          in   1               squash: kill ID issue and entries 0..FLUSH_DEPTH-1
//  id_valid       in   1               ID holds a valid instruction
//  id_src_addr    in   NUM_SRC*REG_AW  source register addresses, src k at [k*REG_AW +: REG_AW]
//  id_src_used    in   NUM_SRC         source k is read by the instruction
//  id_src_rf      in   NUM_SRC*DATA_W  register-file read data per source
//  id_dst_addr    in   REG_AW          destination register of ID instruction
//  id_dst_wen     in   1               ID instruction writes a register
//  id_is_load     in   1               ID instruction is a load
//  stage_data     in   DEPTH*DATA_W    result per tracked stage; stage i at [i*DATA_W +: DATA_W]
//  id_stall       out  1               hold IF/ID, insert bubble into EXE
//  id_opnd        out  NUM_SRC*DATA_W  resolved operand per source
//  fwd_sel        out  NUM_SRC*SELW    SELW=$clog2(DEPTH+1); 0 = regfile, i+1 = stage i
// BEHAVIOUR
//  - Tracker entry fields: {vld, wen, addr, ld}.
//    Reset (async, rst_n=0): every entry's vld/wen/ld = 0 and addr = 0.
//    Outputs after reset: id_stall = 0, fwd_sel = 0, id_opnd = id_src_rf.
//  - Issue condition: iss = id_valid & ~id_stall & ~flush.
//  - Clock edge with pipe_en = 1:
//    - entry[i] <= entry[i-1] for i >= 1.
//    - entry[0] <= iss ? {1, id_dst_wen & (id_dst_addr != 0), id_dst_addr, id_is_load} : bubble.
//  - Clock edge with pipe_en = 0: tracker holds; outputs remain combinational on current inputs.
//  - flush = 1 with pipe_en = 1:
//    - Shift first, then clear vld in the shifted entries at index < FLUSH_DEPTH.
//    - The ID instruction is not issued.
//    - flush has priority over stall.
//  - Match for source k: id_src_used[k] & addr_k != 0 & entry[i].vld & entry[i].wen & entry[i].addr == addr_k.
//    - The lowest matching i (youngest) wins. Older matches are ignored.
//  - Ready: entry[i] is ready when ~ld, or when i >= LOAD_RDY_STG.
//  - Forwarding: a winning ready entry gives fwd_sel_k = i+1 and id_opnd_k = stage_data[i].
//    With no match: fwd_sel_k = 0 and id_opnd_k = id_src_rf[k].
//  - id_stall = id_valid & ~flush & OR over k of (winning entry not ready).
//    - All paths are combinational, zero latency.
//    - A stall re-evaluates each cycle as the load advances.
//  - Load-use with defaults: exactly 1 stall cycle, then forward from MEM (sel = 2).
//  - Same register written by two in-flight stages: the younger value is used.
//  - A WB-stage match forwards even though the regfile writes in the same cycle, so no write-before-read dependency exists.
//  - Reset mid-stall: id_stall drops asynchronously with the tracker.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    - Adds outputs perf_stall_cnt [31:0] and perf_fwd_cnt [31:0].
//    - perf_stall_cnt +1 per cycle with pipe_en & id_stall.
//    - perf_fwd_cnt +1 per issued instruction with any fwd_sel != 0.
//    - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst_n.
//  HAZARD_PERF_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//  1 Reset: rst_n=0 mid-run -> id_stall=0, fwd_sel=0, id_opnd=id_src_rf; after release, no stale forwarding.
//  2 EX fwd: issue add $3 (dst 3); next cycle src0=3, stage_data[0]=32'h1234 -> fwd_sel0=1, id_opnd0=32'h1234, no stall.
//  3 Load-use: issue lw $5; next cycle src1=5 -> id_stall=1 for exactly 1 cycle, bubble in EXE, then fwd_sel1=2 with MEM data.
//  4 Youngest wins: $7 written at stage 2 (32'hAAAA) and stage 0 (32'hBBBB) -> id_opnd=32'hBBBB, sel=1.
//  5 Reg 0 / unused: src=0 with entry dst=0, or id_src_used=0 -> sel=0, no stall.
//  6 Flush/freeze:
//    - flush with lw $5 in entry 0 -> entry killed; dependent $5 read gets regfile data next cycle.
//    - pipe_en=0 for 3 cycles -> tracker unchanged.
//    - HAZARD_PERF_EN: 1 load-use stall -> perf_stall_cnt=1.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard-detection and operand-forwarding unit: tracks in-flight destinations per post-ID stage,
// forwards the youngest ready result to each ID source and stalls ID while it is not ready.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_fwd_unit #(
  parameter  int DATA_W       = 32,
  parameter  int REG_AW       = 5,
  parameter  int NUM_SRC      = 2,
  parameter  int DEPTH        = 3,
  parameter  int LOAD_RDY_STG = 1,
  parameter  int FLUSH_DEPTH  = 1,
  localparam int SELW         = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_en,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_src_rf,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_wen,
  input  logic                      id_is_load,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  output logic                      id_stall,
  output logic [NUM_SRC*DATA_W-1:0] id_opnd,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0]             r_wen;
  logic [DEPTH-1:0]             r_ld;
  logic [DEPTH-1:0][REG_AW-1:0] r_addr;

  logic [DEPTH-1:0]             w_rdy;
  logic [NUM_SRC-1:0]           w_wait;
  logic [NUM_SRC*SELW-1:0]      w_sel;
  logic [NUM_SRC*DATA_W-1:0]    w_opnd;
  logic                         w_iss;

  // A load's data exists only once it reaches LOAD_RDY_STG; everything else is ready in EXE.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rdy[i] = ~r_ld[i] | (i >= LOAD_RDY_STG);
    end
  end

  // NOTE: every output of this block gets a default before the loops so no latch is inferred.
  // Scanning oldest to youngest lets the youngest match overwrite the older ones.
  always_comb begin
    w_sel  = '0;
    w_opnd = id_src_rf;
    w_wait = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (id_src_used[k] && (id_src_addr[k*REG_AW +: REG_AW] != '0) &&
            r_vld[i] && r_wen[i] && (r_addr[i] == id_src_addr[k*REG_AW +: REG_AW])) begin
          w_wait[k]                  = ~w_rdy[i];
          w_sel[k*SELW +: SELW]      = w_rdy[i] ? SELW'(i + 1) : '0;
          w_opnd[k*DATA_W +: DATA_W] = w_rdy[i] ? stage_data[i*DATA_W +: DATA_W]
                                                : id_src_rf[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign id_stall = id_valid & ~flush & (|w_wait);
  assign w_iss    = id_valid & ~id_stall & ~flush;
  assign fwd_sel  = w_sel;
  assign id_opnd  = w_opnd;

  // NOTE: the tracker is a handful of flops, so every field is cleared by reset; state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_wen  <= '0;
      r_ld   <= '0;
      r_addr <= '0;
    end else if (pipe_en) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_wen[i]  <= r_wen[i-1];
        r_ld[i]   <= r_ld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
      r_vld[0]  <= w_iss;
      r_wen[0]  <= w_iss & id_dst_wen & (id_dst_addr != '0);
      r_ld[0]   <= w_iss & id_is_load;
      r_addr[0] <= w_iss ? id_dst_addr : '0;
      // Entries that sat in 0..FLUSH_DEPTH-1 have just moved one slot older; kill them there.
      if (flush) begin
        for (int i = 1; (i <= FLUSH_DEPTH) && (i < DEPTH); i++) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_fwd_cnt;
  logic        w_any_fwd;

  assign w_any_fwd = |w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_fwd_cnt   <= '0;
    end else begin
      if (pipe_en && id_stall && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (pipe_en && w_iss && w_any_fwd && (r_perf_fwd_cnt != '1)) begin
        r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: a per-cycle vector table plus hand-written
// freeze and reset-mid-stall sequences, with expected outputs queued and compared at negedge.
module tb_hazard_fwd_unit;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NS   = 2;
  localparam int D    = 3;
  localparam int SELW = 2;

  localparam logic [31:0] RF0  = 32'hC0DE_0000;
  localparam logic [31:0] RF1  = 32'hC0DE_0001;
  localparam logic [31:0] SDX  = 32'h0DD0_0000;
  localparam logic [31:0] SD1  = 32'h5555_5555;
  localparam logic [31:0] SD2  = 32'h0000_AAAA;
  localparam logic [31:0] DA   = 32'h0000_1234;
  localparam logic [31:0] DB   = 32'h0000_BBBB;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_en, flush, id_valid;
  logic [NS*AW-1:0]  id_src_addr;
  logic [NS-1:0]     id_src_used;
  logic [NS*DW-1:0]  id_src_rf;
  logic [AW-1:0]     id_dst_addr;
  logic              id_dst_wen, id_is_load;
  logic [D*DW-1:0]   stage_data;
  logic              id_stall;
  logic [NS*DW-1:0]  id_opnd;
  logic [NS*SELW-1:0] fwd_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_fwd_cnt;
`endif

  hazard_fwd_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_en     (pipe_en),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_src_rf   (id_src_rf),
    .id_dst_addr (id_dst_addr),
    .id_dst_wen  (id_dst_wen),
    .id_is_load  (id_is_load),
    .stage_data  (stage_data),
    .id_stall    (id_stall),
    .id_opnd     (id_opnd),
    .fwd_sel     (fwd_sel)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic [31:0] op0;
    logic [31:0] op1;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic        pen;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [1:0]  used;
    logic [4:0]  dst;
    logic        wen;
    logic        ld;
    logic [31:0] sd0;
    exp_t        e;
  } vec_t;

  localparam exp_t NOFWD = '{1'b0, 2'd0, 2'd0, RF0, RF1};

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid    = v.valid;
    flush       = v.flush;
    pipe_en     = v.pen;
    id_src_addr = {v.s1, v.s0};
    id_src_used = v.used;
    id_src_rf   = {RF1, RF0};
    id_dst_addr = v.dst;
    id_dst_wen  = v.wen;
    id_is_load  = v.ld;
    stage_data  = {SD2, SD1, v.sd0};
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_stall"}, 32'(id_stall), 32'(e.stall));
      check({tag, "_sel0"},  32'(fwd_sel[1:0]), 32'(e.sel0));
      check({tag, "_sel1"},  32'(fwd_sel[3:2]), 32'(e.sel1));
      check({tag, "_opnd0"}, id_opnd[31:0],  e.op0);
      check({tag, "_opnd1"}, id_opnd[63:32], e.op1);
    end
  endtask

  // Entered at posedge+1: drive, queue the expectation, compare at negedge, move past the next edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    exp_q.push_back(v.e);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // valid flush pen s0 s1 used dst wen ld sd0 {stall sel0 sel1 op0 op1}
    tbl[0]  = '{1'b0,1'b0,1'b1,5'd3,5'd5,2'b11,5'd0,1'b0,1'b0,SDX,NOFWD};
    tbl[1]  = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd3,1'b1,1'b0,SDX,NOFWD};
    tbl[2]  = '{1'b1,1'b0,1'b1,5'd3,5'd0,2'b01,5'd0,1'b0,1'b0,DA, '{1'b0,2'd1,2'd0,DA,RF1}};
    tbl[3]  = '{1'b1,1'b0,1'b1,5'd3,5'd0,2'b01,5'd5,1'b1,1'b1,SDX,'{1'b0,2'd2,2'd0,SD1,RF1}};
    tbl[4]  = '{1'b1,1'b0,1'b1,5'd0,5'd5,2'b10,5'd6,1'b1,1'b0,SDX,'{1'b1,2'd0,2'd0,RF0,RF1}};
    tbl[5]  = '{1'b1,1'b0,1'b1,5'd0,5'd5,2'b10,5'd6,1'b1,1'b0,SDX,'{1'b0,2'd0,2'd2,RF0,SD1}};
    tbl[6]  = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd7,1'b1,1'b0,SDX,NOFWD};
    tbl[7]  = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd8,1'b1,1'b0,SDX,NOFWD};
    tbl[8]  = '{1'b1,1'b0,1'b1,5'd6,5'd0,2'b01,5'd7,1'b1,1'b0,SDX,'{1'b0,2'd3,2'd0,SD2,RF1}};
    tbl[9]  = '{1'b1,1'b0,1'b1,5'd7,5'd7,2'b11,5'd0,1'b0,1'b0,DB, '{1'b0,2'd1,2'd1,DB,DB}};
    tbl[10] = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd0,1'b1,1'b0,SDX,NOFWD};
    tbl[11] = '{1'b1,1'b0,1'b1,5'd0,5'd7,2'b01,5'd0,1'b0,1'b0,SDX,NOFWD};
    tbl[12] = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd5,1'b1,1'b1,SDX,NOFWD};
    tbl[13] = '{1'b1,1'b1,1'b1,5'd0,5'd5,2'b10,5'd9,1'b1,1'b0,SDX,NOFWD};
    tbl[14] = '{1'b1,1'b0,1'b1,5'd9,5'd5,2'b11,5'd0,1'b0,1'b0,SDX,NOFWD};

    rst_n = 1'b0;
    drive(tbl[0]);
    exp_q.push_back(NOFWD);
    #12;
    compare("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 15; n++) begin
      run_vec(tbl[n], $sformatf("vec%0d", n));
    end

`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'd1);
    check("perf_fwd_cnt", perf_fwd_cnt, 32'd5);
`endif

    // Freeze: $9 sits in EXE while pipe_en is low for three cycles.
    v = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd9,1'b1,1'b0,SDX,NOFWD};
    run_vec(v, "frz_issue");
    v = '{1'b1,1'b0,1'b0,5'd9,5'd10,2'b11,5'd10,1'b1,1'b0,DA,'{1'b0,2'd1,2'd0,DA,RF1}};
    for (int n = 0; n < 3; n++) begin
      run_vec(v, $sformatf("frz_hold%0d", n));
    end
    v.pen = 1'b1;
    run_vec(v, "frz_release");
    v = '{1'b1,1'b0,1'b1,5'd9,5'd10,2'b11,5'd0,1'b0,1'b0,DA,'{1'b0,2'd2,2'd1,SD1,DA}};
    run_vec(v, "frz_after");

    // Reset asserted mid-stall drops id_stall without a clock edge and leaves nothing to forward.
    v = '{1'b1,1'b0,1'b1,5'd0,5'd0,2'b00,5'd5,1'b1,1'b1,SDX,NOFWD};
    run_vec(v, "rst_lw");
    v = '{1'b1,1'b0,1'b1,5'd0,5'd5,2'b10,5'd0,1'b0,1'b0,SDX,'{1'b1,2'd0,2'd0,RF0,RF1}};
    drive(v);
    exp_q.push_back(v.e);
    @(negedge clk);
    compare("rst_stall");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(NOFWD);
    compare("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v.e = NOFWD;
    run_vec(v, "rst_after0");
    run_vec(v, "rst_after1");
`ifdef HAZARD_PERF_EN
    check("perf_stall_after_rst", perf_stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
